pulse_burst_controller: RTL and testbench

Sequencer for single-cycle strobes: a rising edge on a start level launches a burst of COUNT registered one-cycle pulses spaced PERIOD cycles apart, then reports completion. Sits beside the edge-to-pulse logic in the core's peripheral/debug path, turning a button- or CSR-driven start level into a timed strobe train for downstream counters, triggers or test hooks. Supports abort, busy indication and a per-pulse index.

---
 rtl/pulse_burst_controller.sv | 136 +++++++++++++
 tb/tb_pulse_burst_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_burst_controller
//  Purpose  : On a rising edge of START_I, emit COUNT_I registered one-cycle
//             pulses spaced PERIOD_I cycles apart. DONE_O strobes once after
//             the final pulse. ABORT_I cancels a running burst silently.
//  Ports    : CLK_I       - clock, rising edge
//             RST_I       - asynchronous active-high reset
//             START_I     - start level, rising edge launches a burst
//             ABORT_I     - level, ends a running burst (no DONE_O)
//             COUNT_I     - pulses per burst, sampled at the accepted start
//             PERIOD_I    - cycles between pulse starts (0 treated as 1)
//             PULSE_O     - one-cycle strobe
//             BUSY_O      - burst in progress
//             DONE_O      - one-cycle completion strobe
//             PULSE_IDX_O - 0-based index of current/most recent pulse
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_burst_controller #(
  parameter int CNT_W = 8,
  parameter int PER_W = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             START_I,
  input  logic             ABORT_I,
  input  logic [CNT_W-1:0] COUNT_I,
  input  logic [PER_W-1:0] PERIOD_I,
  output logic             PULSE_O,
  output logic             BUSY_O,
  output logic             DONE_O,
  output logic [CNT_W-1:0] PULSE_IDX_O
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] perm1_q, perm1_d;   // latched period minus one
  logic [PER_W-1:0] tmr_q, tmr_d;       // cycles left until next pulse
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rise;

  assign rise = START_I & ~start_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      perm1_q <= '0;
      tmr_q   <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= START_I;
      cnt_q   <= cnt_d;
      perm1_q <= perm1_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perm1_d = perm1_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise && !ABORT_I) begin
          if (COUNT_I == '0) begin
            // Empty burst completes immediately without pulsing.
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = COUNT_I;
            perm1_d = (PERIOD_I == '0) ? '0 : (PERIOD_I - PER_W'(1));
            tmr_d   = (PERIOD_I == '0) ? '0 : (PERIOD_I - PER_W'(1));
            idx_d   = '0;
            pulse_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (ABORT_I) begin
          // Abort takes priority over a pulse due this cycle.
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (idx_q == (cnt_q - CNT_W'(1))) begin
          // The final pulse was on the outputs this cycle.
          state_d = ST_IDLE;
          tmr_d   = '0;
          done_d  = 1'b1;
        end else if (tmr_q == '0) begin
          pulse_d = 1'b1;
          idx_d   = idx_q + CNT_W'(1);
          tmr_d   = perm1_q;
        end else begin
          tmr_d = tmr_q - PER_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  assign PULSE_O     = pulse_q;
  assign BUSY_O      = busy_q;
  assign DONE_O      = done_q;
  assign PULSE_IDX_O = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_burst_controller
//  Purpose  : Directed self-checking bench for pulse_burst_controller.
//             Inputs are driven 1 time unit after a rising edge; outputs are
//             sampled at that same point, i.e. away from the active edge.
//             "Step s" means the s-th rising edge after the one that saw
//             the start rise, counted from 1 (step 1 = first pulse).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_burst_controller;

  localparam int CNT_W = 8;
  localparam int PER_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] count;
  logic [PER_W-1:0] period;
  logic             pulse;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] idx;

  int err_cnt;
  int chk_cnt;

  pulse_burst_controller #(
    .CNT_W(CNT_W),
    .PER_W(PER_W)
  ) u_dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .START_I    (start),
    .ABORT_I    (abort),
    .COUNT_I    (count),
    .PERIOD_I   (period),
    .PULSE_O    (pulse),
    .BUSY_O     (busy),
    .DONE_O     (done),
    .PULSE_IDX_O(idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic p, input logic b,
                            input logic d, input int i);
    check({tag, " pulse"}, {31'd0, pulse}, {31'd0, p});
    check({tag, " busy"},  {31'd0, busy},  {31'd0, b});
    check({tag, " done"},  {31'd0, done},  {31'd0, d});
    check({tag, " idx"},   {24'd0, idx},   i);
  endtask

  // Expected outputs at step s of an n-pulse burst with effective period p.
  task automatic step_expect(input string tag, input int s, input int n, input int p);
    int  last;
    logic ep, eb, ed;
    int  ei;
    last = 1 + (n - 1) * p;
    ep   = (s <= last) && (((s - 1) % p) == 0);
    eb   = (s <= last);
    ed   = (s == last + 1);
    ei   = (s <= last) ? (s - 1) / p : n - 1;
    expect_out($sformatf("%s s%0d", tag, s), ep, eb, ed, ei);
  endtask

  task automatic idle_low();
    start = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    count  = '0;
    period = '0;
    #1;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    expect_out("post-reset", 1'b0, 1'b0, 1'b0, 0);

    // Basic burst: 3 pulses, period 4 -> steps 1,5,9; done at 10.
    count = 8'd3; period = 16'd4;
    start = 1'b1;
    for (int s = 1; s <= 11; s++) begin
      tick();
      step_expect("basic", s, 3, 4);
    end
    idle_low();

    // Zero count: done next cycle, no pulse, never busy.
    count = 8'd0; period = 16'd4;
    start = 1'b1;
    tick();
    expect_out("zero s1", 1'b0, 1'b0, 1'b1, 2);
    tick();
    expect_out("zero s2", 1'b0, 1'b0, 1'b0, 2);
    idle_low();

    // Zero period behaves as period 1.
    count = 8'd2; period = 16'd0;
    start = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      tick();
      step_expect("per0", s, 2, 1);
    end
    idle_low();

    // Full-scale count, back-to-back pulses; index ends at 254.
    count = 8'd255; period = 16'd1;
    start = 1'b1;
    for (int s = 1; s <= 257; s++) begin
      tick();
      step_expect("n255", s, 255, 1);
    end
    idle_low();

    // Rise with abort high is ignored.
    count = 8'd3; period = 16'd2;
    abort = 1'b1;
    start = 1'b1;
    tick();
    expect_out("abort-start", 1'b0, 1'b0, 1'b0, 254);
    abort = 1'b0;
    tick();
    expect_out("abort-start hold", 1'b0, 1'b0, 1'b0, 254);
    idle_low();

    // Abort on the edge where the third pulse is due (steps 1,4,7).
    count = 8'd5; period = 16'd3;
    start = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      tick();
      step_expect("abort", s, 5, 3);
    end
    abort = 1'b1;
    tick();
    expect_out("abort cut", 1'b0, 1'b0, 1'b0, 1);
    abort = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      expect_out($sformatf("abort after%0d", s), 1'b0, 1'b0, 1'b0, 1);
    end
    start = 1'b0;
    tick();
    count = 8'd2; period = 16'd2;
    start = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      tick();
      step_expect("fresh", s, 2, 2);
    end
    idle_low();

    // Retrigger during run: start toggles, no extra pulses; burst of 3 @ 3.
    count = 8'd3; period = 16'd3;
    start = 1'b1;
    for (int s = 1; s <= 9; s++) begin
      tick();
      step_expect("retrig", s, 3, 3);
      if (s == 2) start = 1'b0;
      if (s == 3) start = 1'b1;
    end
    idle_low();

    // Rise on the DONE cycle is accepted; first pulse one cycle later.
    count = 8'd2; period = 16'd2;
    start = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      tick();
      step_expect("chain a", s, 2, 2);
      if (s == 1) start = 1'b0;
    end
    count = 8'd2; period = 16'd1;
    start = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      tick();
      step_expect("chain b", s, 2, 1);
    end
    idle_low();

    // Mid-burst input changes are ignored.
    count = 8'd2; period = 16'd3;
    start = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      tick();
      step_expect("stable", s, 2, 3);
      if (s == 1) begin
        count  = 8'd7;
        period = 16'd1;
      end
    end
    idle_low();

    // Asynchronous reset mid-burst, released with start held high.
    count = 8'd4; period = 16'd2;
    start = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      tick();
      step_expect("rst pre", s, 4, 2);
    end
    #1;
    rst = 1'b1;
    #1;
    expect_out("rst async", 1'b0, 1'b0, 1'b0, 0);
    #1;
    rst = 1'b0;
    for (int s = 1; s <= 9; s++) begin
      tick();
      step_expect("rst post", s, 4, 2);
    end
    idle_low();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
